// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped LSB first
// over WIDTH cycles with a registered carry, valid/ready on both sides.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   InValid/InReady   operand handshake; A, B, Cin, Sub sampled on accept
//   OutValid/OutReady result handshake; S, Cout, Ovf held while OutValid
//   Busy              high while an operation is running or awaiting pickup
module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [WIDTH-1:0] aSr;
    logic [WIDTH-1:0] bSr;
    logic [WIDTH-1:0] sSr;
    logic [CNTW-1:0]  cnt;
    logic             carry;
    logic             carryMsb;
    logic             coutR;
    logic             ovfR;
    // Set after the MSB has been processed; RUN then spends one more
    // cycle before presenting the result.
    logic             settle;

    logic sumBit;
    logic cellCout;
    logic lastBit;
    logic msbInBit;

    assign sumBit   = aSr[0] ^ bSr[0] ^ carry;
    assign cellCout = (aSr[0] & bSr[0]) | (carry & (aSr[0] ^ bSr[0]));
    assign lastBit  = (cnt == CNTW'(WIDTH - 1));
    assign msbInBit = (cnt == CNTW'(WIDTH - 2));

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (InValid)  stateNext = RUN;
            RUN:  if (settle)   stateNext = DONE;
            DONE: if (OutReady) stateNext = IDLE;
            default:            stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            aSr      <= '0;
            bSr      <= '0;
            sSr      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            carryMsb <= 1'b0;
            coutR    <= 1'b0;
            ovfR     <= 1'b0;
            settle   <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (InValid) begin
                        aSr    <= A;
                        bSr    <= Sub ? ~B : B;
                        carry  <= Sub ? 1'b1 : Cin;
                        cnt    <= '0;
                        settle <= 1'b0;
                    end
                end
                RUN: begin
                    if (!settle) begin
                        sSr   <= {sumBit, sSr[WIDTH-1:1]};
                        aSr   <= aSr >> 1;
                        bSr   <= bSr >> 1;
                        carry <= cellCout;
                        cnt   <= cnt + CNTW'(1);
                        // carry out of bit WIDTH-2 is the carry into the MSB
                        if (msbInBit) carryMsb <= cellCout;
                        if (lastBit) begin
                            coutR  <= cellCout;
                            ovfR   <= carryMsb ^ cellCout;
                            settle <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);
    assign Busy     = (state == RUN) || (state == DONE);
    assign S        = sSr;
    assign Cout     = coutR;
    assign Ovf      = ovfR;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): directed vectors push
// expected results; a negedge monitor checks them on each output handshake.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       InValid = 1'b0;
    logic       InReady;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Cin = 1'b0;
    logic       Sub = 1'b0;
    logic       OutValid;
    logic       OutReady = 1'b1;
    logic [7:0] S;
    logic       Cout;
    logic       Ovf;
    logic       Busy;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .OutValid(OutValid),
        .OutReady(OutReady), .S(S), .Cout(Cout), .Ovf(Ovf), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   prevValid = 1'b0;
    bit   expectIdle = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: latency on OutValid rise, values on handshake, idle after
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (expectIdle) begin
                check("inReadyAfterPop", int'(InReady), 1);
                check("outValidAfterPop", int'(OutValid), 0);
                expectIdle = 1'b0;
            end
            if (OutValid && !prevValid) begin
                if (q.size() == 0)
                    check("unexpectedOutValid", 1, 0);
                else
                    check("latency", cyc - q[0].acc, 9);
            end
            if (OutValid) check("inReadyInDone", int'(InReady), 0);
            if (OutValid && OutReady && q.size() > 0) begin
                e = q.pop_front();
                check("S", int'(S), int'(e.s));
                check("Cout", int'(Cout), int'(e.c));
                check("Ovf", int'(Ovf), int'(e.o));
                expectIdle = 1'b1;
            end
            prevValid = OutValid;
        end else begin
            prevValid = 1'b0;
            expectIdle = 1'b0;
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (!(InReady && q.size() == 0 && !expectIdle) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("idleTimeout", 0, 1);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         input logic [7:0] s, input logic c, input logic o,
                         input bit track);
        @(negedge clk);
        A = a; B = b; Cin = cin; Sub = sub; InValid = 1'b1;
        @(posedge clk);
        #1;
        InValid = 1'b0;
        if (track) q.push_back('{s, c, o, cyc});
    endtask

    initial begin
        // reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstInReady", int'(InReady), 1);
            check("rstOutValid", int'(OutValid), 0);
            check("rstBusy", int'(Busy), 0);
            check("rstS", int'(S), 0);
        end

        // directed arithmetic vectors
        issue(8'h3C, 8'h25, 1'b1, 1'b0, 8'h62, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("busyInRun", int'(Busy), 1);
        check("inReadyInRun", int'(InReady), 0);
        waitIdle();
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        waitIdle();
        issue(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        waitIdle();
        issue(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
        waitIdle();
        issue(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        waitIdle();

        // backpressure with inputs toggling during RUN
        OutReady = 1'b0;
        issue(8'h5A, 8'hC3, 1'b0, 1'b0, 8'h1D, 1'b1, 1'b0, 1'b1);
        InValid = 1'b1;
        for (int n = 0; n < 30 && !OutValid; n++) begin
            @(negedge clk);
            A = 8'($urandom);
            B = 8'($urandom);
            Cin = 1'($urandom);
            Sub = 1'($urandom);
        end
        check("bpOutValid", int'(OutValid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bpHoldS", int'(S), 8'h1D);
            check("bpHoldCout", int'(Cout), 1);
            check("bpHoldOvf", int'(Ovf), 0);
            check("bpHoldValid", int'(OutValid), 1);
            check("bpInReady", int'(InReady), 0);
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        waitIdle();

        // reset in RUN cycle 3 abandons the operation
        issue(8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midRstBusy", int'(Busy), 0);
        check("midRstInReady", int'(InReady), 1);
        repeat (14) @(negedge clk);
        check("midRstNoValid", int'(OutValid), 0);

        issue(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        waitIdle();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
